// File: rtl/feistel_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : feistel_decrypt_core
// Brief    : Iterative Feistel decryptor, one round per clock, keys applied
//            in reverse order through an index/key lookup port.
//            Optional simulation trace enabled by FEISTEL_DEC_TRACE_EN.
// Revision : 1.0
// ============================================================================
module feistel_decrypt_core #(
  parameter  int ROUNDS = 16,
  localparam int KIW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [63:0]    cipher_in,
  output logic [KIW-1:0] key_idx,
  input  logic [47:0]    round_key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [63:0]    plain_out,
  output logic           busy
);

  localparam logic [KIW-1:0] LAST_RND = KIW'(ROUNDS - 1);
  localparam logic [31:0]    F_MASK   = 32'h5A5A5A5A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    l_q, l_d;
  logic [31:0]    r_q, r_d;
  logic [KIW-1:0] rnd_q, rnd_d;
  logic [63:0]    plain_q, plain_d;
  logic [31:0]    f_out;

  // Must stay bit-exact with the encryptor's round function.
  function automatic logic [31:0] f_round(input logic [31:0] x, input logic [47:0] k);
    logic [47:0] e;
    logic [47:0] y;
    logic [31:0] c;
    e = {x[31:16], x[31:16], x[15:0]};
    y = e ^ k;
    c = {y[47:40] ^ y[39:32], y[31:24] ^ y[23:16], y[15:8] ^ y[7:0], 8'hAA};
    return {c[30:0], c[31]} ^ F_MASK;
  endfunction

  assign f_out = f_round(l_q, round_key);

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    rnd_d   = rnd_q;
    plain_d = plain_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          l_d     = cipher_in[63:32];
          r_d     = cipher_in[31:0];
          rnd_d   = LAST_RND;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        l_d = r_q ^ f_out;
        r_d = l_q;
        if (rnd_q == '0) begin
          plain_d = {r_q ^ f_out, l_q};
          state_d = S_DONE;
        end else begin
          rnd_d = rnd_q - 1'b1;
        end
      end
      S_DONE: begin
        // Result is held untouched until the consumer takes it.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      rnd_q   <= '0;
      plain_q <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      rnd_q   <= rnd_d;
      plain_q <= plain_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    key_idx   = (state_q == S_RUN) ? rnd_q : '0;
    plain_out = plain_q;
  end

`ifdef FEISTEL_DEC_TRACE_EN
  always @(posedge clk) begin
    if (rst_n && state_q == S_RUN) begin
      $display("FeistelDec: rnd=%0d L=%h R=%h Key=%h F=%h", rnd_q, l_q, r_q, round_key, f_out);
      if (rnd_q == '0) begin
        $display("FeistelDec: plain=%h", plain_d);
      end
    end
  end
`else
  // Trace disabled: no simulation-only logic is compiled.
`endif

endmodule
`default_nettype wire
